axi_rd_data_rx: RTL and testbench
=================================

Name: axi_rd_data_rx

Overview:
Parametrised AXI4 read-data-channel receiver and the successor to the pass-through read channel. Accepts R-channel beats into an internal DEPTH-entry buffer and drives RREADY from buffer occupancy, so no beat is ever lost. Presents a valid/ready stream to the read-side FIFO logic. Tracks burst framing against the expected burst length and raises sticky protocol and response error flags.

Parameters:
DATA_WIDTH, 64, width of RDATA and of the output data.
DEPTH, 4, number of buffer entries; power of two, at least 2.
BURST_LEN, 16, expected beats per read burst, range 1..256.
LVL_W, $clog2(DEPTH+1), width of fifo_level.

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  asynchronous active-low reset
M_AXI_RDATA  in  DATA_WIDTH  read data
M_AXI_RRESP  in  2  read response
M_AXI_RVALID  in  1  beat valid
M_AXI_RLAST  in  1  last beat of burst
M_AXI_RREADY  out  1  beat accept
out_data  out  DATA_WIDTH  buffered data
out_last  out  1  locally generated end-of-burst marker
out_valid  out  1  head entry valid
out_ready  in  1  downstream accept
burst_done  out  1  one-cycle pulse after the final beat of a burst is accepted
err_clear  in  1  synchronous clear of all sticky error flags
err_early_last  out  1  sticky: RLAST arrived before beat BURST_LEN
err_missing_last  out  1  sticky: beat BURST_LEN arrived without RLAST
err_resp  out  1  sticky: an accepted beat had RRESP != 2'b00
fifo_level  out  LVL_W  current occupancy

Behaviour:
- Reset is asynchronous on the falling edge of M_AXI_ARESETN. While reset is held: buffer empty, all flags 0, burst_done 0, beat counter 0, state IDLE.
- Upstream handshake: push = M_AXI_RVALID && M_AXI_RREADY.
  - M_AXI_RREADY = (occupancy register != DEPTH). It is a decode of flops only and has no combinational path from any input.
  - A push is never lost: a push can only occur when at least one entry is free.
- Downstream handshake: pop = out_valid && out_ready.
  - out_valid = (occupancy != 0). out_data and out_last come from the head entry.
  - out_data and out_last hold steady while out_valid && !out_ready.
- Latency: a beat accepted at edge N gives out_valid=1 after edge N. There is no same-cycle bypass.
- Simultaneous push and pop: occupancy is unchanged and both happen. When full, only pop is possible; when empty, only push is possible.
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- Beat counter (8 bits) and state machine:
  - IDLE: the first push goes to BURST with counter=1. If BURST_LEN==1, that beat is handled as the final beat (see below).
  - BURST: each push increments the counter.
  - Final beat = the push with counter+1 == BURST_LEN (counter == BURST_LEN-1 before the push). On the final beat: out_last stored as 1, burst_done pulses on the next cycle, state returns to IDLE, counter is set to 0.
  - RLAST on a non-final beat: set err_early_last, store out_last=1, pulse burst_done, return to IDLE. This resynchronises framing to the master.
  - Final beat with RLAST=0: set err_missing_last. Framing still closes locally on that beat.
- err_resp is set on any push with RRESP != 0. The data is still buffered.
- err_clear: clears all flags at the next edge. If a set event occurs in the same cycle, set wins.
- Reset mid-burst: buffer contents are discarded and framing restarts in IDLE. Beats of the interrupted burst that arrive after reset count as a new burst.

Optional Feature:
Macro AXI_RD_STATS_EN.
- Defined: adds output stat_beats (32 bits, increments on every push) and output stat_stall (32 bits, increments on every cycle with M_AXI_RVALID && !M_AXI_RREADY).
  - Both saturate at 32'hFFFFFFFF.
  - Both reset to 0.
  - Both are also cleared by err_clear.
- Not defined: neither port nor either counter exists. All other behaviour is identical.

Test Plan:
- DEPTH=4, BURST_LEN=4, out_ready=1, four back-to-back beats 0xA0..0xA3 with RLAST on the 4th -> out_data A0..A3 each one cycle after acceptance; out_last=1 only on A3; one burst_done pulse; all flags 0.
- out_ready=0, RVALID held high with 6 beats -> exactly 4 accepted, RREADY=0 and fifo_level=4. Raise out_ready -> all 6 delivered in order with no gaps or duplicates.
- BURST_LEN=4, RLAST on beat 2 -> err_early_last=1, out_last=1 on beat 2, burst_done pulse. The next beat is counted as beat 1 of a new burst.
- BURST_LEN=4, no RLAST on beat 4 -> err_missing_last=1, out_last=1 on beat 4. Pulse err_clear -> flag 0 the next cycle.
- Beat with RRESP=2'b10 accepted in the same cycle err_clear=1 -> err_resp reads 1 afterwards (set wins); data still delivered.
- Assert reset with 3 entries buffered mid-burst -> out_valid=0, fifo_level=0, RREADY=1 after release. With AXI_RD_STATS_EN defined, stat_beats=0.

Source files
------------

// File: rtl/axi_rd_data_rx.sv
// rtl/axi_rd_data_rx.sv - AXI4 R-channel receiver with beat buffer, burst framing and sticky error flags
// Optional statistics counters are enabled with `define AXI_RD_STATS_EN.
module axi_rd_data_rx #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int BURST_LEN  = 16,
    parameter int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    input  logic                  M_AXI_RLAST,
    output logic                  M_AXI_RREADY,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  burst_done,
    input  logic                  err_clear,
    output logic                  err_early_last,
    output logic                  err_missing_last,
    output logic                  err_resp,
    output logic [LVL_W-1:0]      fifo_level
`ifdef AXI_RD_STATS_EN
    ,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_stall
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state, state_nxt;
    logic [7:0]            beat_cnt, beat_cnt_nxt;
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic                  mem_last [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      count;
    logic                  push, pop, final_beat, close_burst;

    // Ready depends only on the occupancy register, never on RVALID.
    assign M_AXI_RREADY = (count != LVL_W'(DEPTH));
    assign out_valid    = (count != '0);
    assign push         = M_AXI_RVALID && M_AXI_RREADY;
    assign pop          = out_valid && out_ready;
    assign out_data     = mem_data[rd_ptr];
    assign out_last     = mem_last[rd_ptr];
    assign fifo_level   = count;

    // Counter is 0 in IDLE, so BURST_LEN==1 makes the first beat final.
    assign final_beat   = (beat_cnt == 8'(BURST_LEN - 1));
    assign close_burst  = final_beat || M_AXI_RLAST;

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        if (push) begin
            if (close_burst) begin
                state_nxt    = IDLE;
                beat_cnt_nxt = '0;
            end else begin
                state_nxt    = BURST;
                beat_cnt_nxt = beat_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (push) begin
            mem_data[wr_ptr] <= M_AXI_RDATA;
            mem_last[wr_ptr] <= close_burst;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as err_clear wins.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            burst_done       <= 1'b0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
            err_resp         <= 1'b0;
        end else begin
            burst_done <= push && close_burst;
            if (push && M_AXI_RLAST && !final_beat) err_early_last <= 1'b1;
            else if (err_clear)                     err_early_last <= 1'b0;
            if (push && final_beat && !M_AXI_RLAST) err_missing_last <= 1'b1;
            else if (err_clear)                     err_missing_last <= 1'b0;
            if (push && (M_AXI_RRESP != 2'b00))     err_resp <= 1'b1;
            else if (err_clear)                     err_resp <= 1'b0;
        end
    end

`ifdef AXI_RD_STATS_EN
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else if (err_clear) begin
            stat_beats <= '0;
            stat_stall <= '0;
        end else begin
            if (push && (stat_beats != 32'hFFFF_FFFF))
                stat_beats <= stat_beats + 32'd1;
            if (M_AXI_RVALID && !M_AXI_RREADY && (stat_stall != 32'hFFFF_FFFF))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_data_rx.sv
// tb/tb_axi_rd_data_rx.sv - directed self-checking bench for axi_rd_data_rx (DEPTH=4, BURST_LEN=4)
module tb_axi_rd_data_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rlast, rready;
    logic [63:0] out_data;
    logic        out_last, out_valid, out_ready;
    logic        burst_done, err_clear;
    logic        err_early_last, err_missing_last, err_resp;
    logic [2:0]  fifo_level;
`ifdef AXI_RD_STATS_EN
    logic [31:0] stat_beats, stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_rd_data_rx #(.DATA_WIDTH(64), .DEPTH(4), .BURST_LEN(4)) dut (
        .M_AXI_ACLK      (clk),
        .M_AXI_ARESETN   (rst_n),
        .M_AXI_RDATA     (rdata),
        .M_AXI_RRESP     (rresp),
        .M_AXI_RVALID    (rvalid),
        .M_AXI_RLAST     (rlast),
        .M_AXI_RREADY    (rready),
        .out_data        (out_data),
        .out_last        (out_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .burst_done      (burst_done),
        .err_clear       (err_clear),
        .err_early_last  (err_early_last),
        .err_missing_last(err_missing_last),
        .err_resp        (err_resp),
        .fifo_level      (fifo_level)
`ifdef AXI_RD_STATS_EN
        ,
        .stat_beats      (stat_beats),
        .stat_stall      (stat_stall)
`endif
    );

    task automatic do_reset();
        rst_n     = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        out_ready = 1'b0;
        err_clear = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic l, input logic [1:0] r);
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = d;
        rlast  = l;
        rresp  = r;
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        checks++;
        if ({rready, out_valid, fifo_level, burst_done, err_early_last, err_missing_last, err_resp} !== {1'b1, 1'b0, 3'd0, 4'b0}) begin
            errors++;
            $display("FAIL reset_state: rready=%b out_valid=%b level=%0d done=%b flags=%b%b%b required 1 0 0 0 000",
                     rready, out_valid, fifo_level, burst_done, err_early_last, err_missing_last, err_resp);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(64'hA0 + 64'(i), (i == 3), 2'b00);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'hA0 + 64'(i) || out_last !== (i == 3) || burst_done !== (i == 3)) begin
                errors++;
                $display("FAIL b2b_beat%0d: valid=%b data=%h last=%b done=%b required 1 %h %b %b",
                         i, out_valid, out_data, out_last, burst_done, 64'hA0 + 64'(i), (i == 3), (i == 3));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (burst_done !== 1'b0 || out_valid !== 1'b0 || {err_early_last, err_missing_last, err_resp} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_after: done=%b valid=%b flags=%b%b%b required 0 0 000",
                     burst_done, out_valid, err_early_last, err_missing_last, err_resp);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] got [$];
        int idx;
        logic acc;
        do_reset();
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (cyc == 6) begin
                checks++;
                if (idx !== 4 || rready !== 1'b0 || fifo_level !== 3'd4) begin
                    errors++;
                    $display("FAIL bp_full: accepted=%0d rready=%b level=%0d required 4 0 4", idx, rready, fifo_level);
                end
            end
            out_ready = (cyc >= 6);
            rvalid    = (idx < 6);
            rdata     = 64'hB0 + 64'(idx);
            rlast     = (idx == 3);
            acc       = rvalid && rready;
            if (out_valid && out_ready) got.push_back(out_data);
            @(posedge clk);
            if (acc) idx++;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        checks++;
        if (got.size() !== 6) begin
            errors++;
            $display("FAIL bp_count: delivered=%0d required 6", got.size());
        end
        for (int i = 0; i < got.size() && i < 6; i++) begin
            checks++;
            if (got[i] !== 64'hB0 + 64'(i)) begin
                errors++;
                $display("FAIL bp_order%0d: data=%h required %h", i, got[i], 64'hB0 + 64'(i));
            end
        end
    endtask

    task automatic test_early_last();
        logic [5:0] lasts;
        lasts = 6'b100010;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_beat(64'hE0 + 64'(i), lasts[i], 2'b00);
            checks++;
            if (out_last !== lasts[i] || burst_done !== lasts[i] || out_data !== 64'hE0 + 64'(i)) begin
                errors++;
                $display("FAIL early_beat%0d: last=%b done=%b data=%h required %b %b %h",
                         i, out_last, burst_done, out_data, lasts[i], lasts[i], 64'hE0 + 64'(i));
            end
            if (i == 1) begin
                checks++;
                if (err_early_last !== 1'b1) begin
                    errors++;
                    $display("FAIL early_flag: err_early_last=%b required 1", err_early_last);
                end
            end
        end
        checks++;
        if (err_missing_last !== 1'b0 || err_early_last !== 1'b1) begin
            errors++;
            $display("FAIL early_resync: missing=%b early=%b required 0 1", err_missing_last, err_early_last);
        end
    endtask

    task automatic test_missing_last();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(64'hD0 + 64'(i), 1'b0, 2'b00);
        checks++;
        if (out_last !== 1'b1 || burst_done !== 1'b1 || err_missing_last !== 1'b1 || err_early_last !== 1'b0) begin
            errors++;
            $display("FAIL missing_beat4: last=%b done=%b missing=%b early=%b required 1 1 1 0",
                     out_last, burst_done, err_missing_last, err_early_last);
        end
        @(posedge clk); #1;
        checks++;
        if (err_missing_last !== 1'b1) begin
            errors++;
            $display("FAIL missing_sticky: err_missing_last=%b required 1", err_missing_last);
        end
        @(negedge clk);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        checks++;
        if (err_missing_last !== 1'b0) begin
            errors++;
            $display("FAIL missing_clear: err_missing_last=%b required 0", err_missing_last);
        end
    endtask

    task automatic test_resp_clear();
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        err_clear = 1'b1;
        rvalid    = 1'b1;
        rdata     = 64'hC5;
        rresp     = 2'b10;
        @(posedge clk); #1;
        err_clear = 1'b0;
        rvalid    = 1'b0;
        rresp     = 2'b00;
        checks++;
        if (err_resp !== 1'b1 || out_valid !== 1'b1 || out_data !== 64'hC5) begin
            errors++;
            $display("FAIL resp_set_wins: err_resp=%b valid=%b data=%h required 1 1 c5", err_resp, out_valid, out_data);
        end
        @(negedge clk);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        checks++;
        if (err_resp !== 1'b0) begin
            errors++;
            $display("FAIL resp_clear: err_resp=%b required 0", err_resp);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(64'hF0 + 64'(i), 1'b0, 2'b00);
        checks++;
        if (fifo_level !== 3'd3) begin
            errors++;
            $display("FAIL mid_level: level=%0d required 3", fifo_level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL mid_async: valid=%b level=%0d required 0 0", out_valid, fifo_level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rready !== 1'b1 || out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL mid_release: rready=%b valid=%b level=%0d required 1 0 0", rready, out_valid, fifo_level);
        end
`ifdef AXI_RD_STATS_EN
        checks++;
        if (stat_beats !== 32'd0) begin
            errors++;
            $display("FAIL mid_stats: stat_beats=%0d required 0", stat_beats);
        end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(64'h10 + 64'(i), (i == 3), 2'b00);
        checks++;
        if (burst_done !== 1'b1 || out_last !== 1'b1 || err_early_last !== 1'b0 || err_missing_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_newburst: done=%b last=%b early=%b missing=%b required 1 1 0 0",
                     burst_done, out_last, err_early_last, err_missing_last);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_resp_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
